// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN computes multiplies in one step from a 33x33 signed product.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               is_div_s, a_signed_s, b_signed_s, sa_s, sb_s;
  logic               div0_s, ovf_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, special_s;
  logic [2*WIDTH-1:0] step_acc_s, prod_s;
  logic [WIDTH:0]     trial_s, diff_s;
  logic [WIDTH-1:0]   div_val_s, final_s;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod_s;
  logic [WIDTH-1:0]   fast_res_s;
`endif

  // Decode operand signedness, magnitudes and divide special cases at request time.
  always_comb begin
    is_div_s   = funct3[2];
    a_signed_s = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa_s       = a_signed_s & operand_a[WIDTH-1];
    sb_s       = b_signed_s & operand_b[WIDTH-1];
    mag_a_s    = sa_s ? ({WIDTH{1'b0}} - operand_a) : operand_a;
    mag_b_s    = sb_s ? ({WIDTH{1'b0}} - operand_b) : operand_b;
    div0_s     = (operand_b == {WIDTH{1'b0}});
    ovf_s      = !funct3[0] && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == {WIDTH{1'b1}});
    if (div0_s) begin
      special_s = funct3[1] ? operand_a : {WIDTH{1'b1}};
    end else begin
      special_s = funct3[1] ? {WIDTH{1'b0}} : operand_a;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_prod_s = (2*WIDTH)'($signed({sa_s, operand_a}) * $signed({sb_s, operand_b}));
    fast_res_s  = (funct3[1:0] == 2'b00) ? fast_prod_s[WIDTH-1:0] : fast_prod_s[2*WIDTH-1:WIDTH];
`endif
  end

  // One datapath iteration plus the sign-corrected result used on the last iteration.
  always_comb begin
    trial_s = acc_q[2*WIDTH-1:WIDTH-1];
    diff_s  = trial_s - {1'b0, mcand_q[WIDTH-1:0]};
    if (op_q[2]) begin
      // Restoring divide: acc holds {remainder, dividend/quotient}.
      step_acc_s = {(diff_s[WIDTH] ? trial_s[WIDTH-1:0] : diff_s[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], ~diff_s[WIDTH]};
    end else begin
      step_acc_s = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
    end
    prod_s    = neg_q ? ({2*WIDTH{1'b0}} - step_acc_s) : step_acc_s;
    div_val_s = op_q[1] ? step_acc_s[2*WIDTH-1:WIDTH] : step_acc_s[WIDTH-1:0];
    if (op_q[2]) begin
      final_s = neg_q ? ({WIDTH{1'b0}} - div_val_s) : div_val_s;
    end else begin
      final_s = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state and next-datapath computation for the IDLE/CALC/FINISH sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = funct3;
          neg_d = (is_div_s && funct3[1]) ? sa_s : (sa_s ^ sb_s);
          cnt_d = CW'(WIDTH);
          if (is_div_s && (div0_s || ovf_s)) begin
            state_d  = FINISH;
            result_d = special_s;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div_s) begin
            state_d  = FINISH;
            result_d = fast_res_s;
`endif
          end else if (is_div_s) begin
            state_d  = CALC;
            acc_d    = {{WIDTH{1'b0}}, mag_a_s};
            mcand_d  = {{WIDTH{1'b0}}, mag_b_s};
            mplier_d = {WIDTH{1'b0}};
          end else begin
            state_d  = CALC;
            acc_d    = {2*WIDTH{1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, mag_a_s};
            mplier_d = mag_b_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d    = step_acc_s;
        mcand_d  = op_q[2] ? mcand_q : (mcand_q << 1);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = FINISH;
          result_d = final_s;
        end else begin
          state_d = CALC;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC);
    done_d = (state_d == FINISH);
  end

  // State, datapath and output registers; async reset discards any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      acc_q    <= {2*WIDTH{1'b0}};
      mcand_q  <= {2*WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at request, compared on done.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; done is expected after edge 'lat' counted from the sampling edge.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    logic [31:0] e;
    bit seen = 1'b0;
    sb_q.push_back(exp);
    funct3 = f; operand_a = a; operand_b = b; start = 1'b1;
    for (int i = 1; i <= lat + 3; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      check_eq({tag, "_busy"}, 32'(busy), (i < lat) ? 32'd1 : 32'd0);
      check_eq({tag, "_done"}, 32'(done), (i == lat) ? 32'd1 : 32'd0);
      if (done && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq(tag, result, e);
        seen = 1'b1;
      end
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end
    check_eq({tag, "_hold"}, result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] e;
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    run_op("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
    run_op("mul_big", 3'b000, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, MUL_LAT);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
    run_op("divu",    3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT);
    run_op("remu",    3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT);
    run_op("div_neg_b", 3'b100, 32'd100,    32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT);
    run_op("divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_z",  3'b111, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_z",   3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_z",   3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // A second start during CALC must be ignored.
    sb_q.push_back(32'd14);
    funct3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (i == 5) begin
        start = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd3;
      end
      check_eq("ign_done", 32'(done), (i == DIV_LAT) ? 32'd1 : 32'd0);
      if (done && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("ign_result", result, e);
      end
    end
    check_eq("ign_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset in the middle of a divide.
    funct3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_result", result, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      check_eq("post_rst_done", 32'(done), 32'd0);
    end
    run_op("divu_after_rst", 3'b101, 32'd9, 32'd3, 32'd3, DIV_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
